// File: rtl/universal_shift.sv
// Universal shift register: parallel load, single-step shifts and counted bursts
// of shl/shr/rotl/rotr, with a one-cycle done pulse at the end of each burst.
module universal_shift #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic             en,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] out,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0]       sh_mode;
    logic [WIDTH-1:0] shifted;
    logic             shift_bit;
    logic             pulse;

    // A running burst uses its latched mode; idle single steps use the live mode.
    assign sh_mode = (state_q == StShift) ? mode_q : mode;

    always_comb begin
        shifted   = out_q;
        shift_bit = 1'b0;
        unique case (sh_mode)
            2'b00: begin
                shifted   = {out_q[WIDTH-2:0], sin};
                shift_bit = out_q[WIDTH-1];
            end
            2'b01: begin
                shifted   = {sin, out_q[WIDTH-1:1]};
                shift_bit = out_q[0];
            end
            2'b10: begin
                shifted   = {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                shift_bit = out_q[WIDTH-1];
            end
            2'b11: begin
                shifted   = {out_q[0], out_q[WIDTH-1:1]};
                shift_bit = out_q[0];
            end
            default: begin
                shifted   = out_q;
                shift_bit = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        sout_d  = sout_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        pulse   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    out_d = din;
                end else if (start) begin
                    if (count == '0) begin
                        pulse = 1'b1;
                    end else begin
                        state_d = StShift;
                        cnt_d   = count;
                        mode_d  = mode;
                    end
                end else if (en) begin
                    out_d  = shifted;
                    sout_d = shift_bit;
                end
            end
            StShift: begin
                if (load) begin
                    out_d   = din;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    out_d  = shifted;
                    sout_d = shift_bit;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        pulse   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // A zero-length start right after a burst end would otherwise stretch done.
        done_d = pulse & ~done_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            sout_q  <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out  = out_q;
    assign sout = sout_q;
    assign busy = (state_q == StShift);
    assign done = done_q;

endmodule

// File: tb/tb_universal_shift.sv
// Self-checking bench for universal_shift: directed scenarios plus randomized
// traffic compared cycle by cycle against an arithmetic reference model.
module tb_universal_shift;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] din;
    logic [1:0]   mode;
    logic         sin;
    logic         en;
    logic         start;
    logic [C-1:0] count;
    logic [W-1:0] out;
    logic         sout;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [W-1:0] m_out;
    logic         m_sout;
    logic         m_busy;
    logic         m_done;
    int           m_rem;
    logic [1:0]   m_mode;

    universal_shift #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .din   (din),
        .mode  (mode),
        .sin   (sin),
        .en    (en),
        .start (start),
        .count (count),
        .out   (out),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        load = 0; din = '0; mode = 2'b00; sin = 0; en = 0; start = 0; count = '0;
    endtask

    // Inputs are changed 1 time unit after a rising edge, outputs sampled there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst = 1'b0;
        #12 rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Shift by value arithmetic: multiply/divide by two and add the incoming bit.
    task automatic model_shift(input logic [1:0] md);
        int v;
        int b;
        v = int'(m_out);
        case (md)
            2'b00: begin b = v / 128; v = (v * 2) % 256 + int'(sin); end
            2'b01: begin b = v % 2;   v = v / 2 + int'(sin) * 128; end
            2'b10: begin b = v / 128; v = (v * 2) % 256 + b; end
            default: begin b = v % 2; v = v / 2 + b * 128; end
        endcase
        m_out  = v[7:0];
        m_sout = (b != 0);
    endtask

    task automatic model_edge();
        logic pulse;
        pulse = 0;
        if (!m_busy) begin
            if (load) m_out = din;
            else if (start) begin
                if (count == 0) pulse = 1;
                else begin m_busy = 1; m_rem = int'(count); m_mode = mode; end
            end else if (en) model_shift(mode);
        end else begin
            if (load) begin
                m_out = din; m_busy = 0; m_rem = 0;
            end else begin
                model_shift(m_mode);
                m_rem = m_rem - 1;
                if (m_rem == 0) begin m_busy = 0; pulse = 1; end
            end
        end
        m_done = pulse && !m_done;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        #3;
        checks++; if (out !== 8'h00) begin failures++; $display("FAIL reset_out got=%h exp=00", out); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL reset_sout got=%b exp=0", sout); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        #9 rst = 1'b1;
        step();
    endtask

    task automatic test_single_shift();
        load = 1; din = 8'hA5; step(); load = 0;
        checks++; if (out !== 8'hA5) begin failures++; $display("FAIL load_out got=%h exp=a5", out); end
        en = 1; mode = 2'b00; sin = 1; step(); en = 0; sin = 0;
        checks++; if (out !== 8'h4B) begin failures++; $display("FAIL shl_out got=%h exp=4b", out); end
        checks++; if (sout !== 1'b1) begin failures++; $display("FAIL shl_sout got=%b exp=1", sout); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL shl_done got=%b exp=0", done); end
    endtask

    task automatic test_burst_rotr();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 8'hC0; exp_seq[1] = 8'h60; exp_seq[2] = 8'h30;
        load = 1; din = 8'h81; step(); load = 0;
        start = 1; count = 3; mode = 2'b11; step();
        // Live mode/count changes must not disturb the latched burst.
        start = 0; count = 9; mode = 2'b00;
        checks++; if (out !== 8'h81 || busy !== 1'b1) begin
            failures++; $display("FAIL rotr_accept got out=%h busy=%b exp out=81 busy=1", out, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (out !== exp_seq[i]) begin
                failures++; $display("FAIL rotr_step%0d got=%h exp=%h", i, out, exp_seq[i]);
            end
            checks++; if (busy !== (i < 2) || done !== (i == 2)) begin
                failures++; $display("FAIL rotr_flags%0d got busy=%b done=%b", i, busy, done);
            end
        end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL rotr_sout got=%b exp=0", sout); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rotr_done_len got=%b exp=0", done); end
    endtask

    task automatic test_burst_shr();
        int ndone;
        ndone = 0;
        load = 1; din = 8'h00; step(); load = 0;
        start = 1; count = 4; mode = 2'b01; sin = 1; step(); start = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done === 1'b1) ndone++;
        end
        sin = 0;
        checks++; if (out !== 8'hF0) begin failures++; $display("FAIL shr_out got=%h exp=f0", out); end
        checks++; if (ndone != 1) begin failures++; $display("FAIL shr_done_cnt got=%0d exp=1", ndone); end
        checks++; if (sout !== 1'b0) begin failures++; $display("FAIL shr_sout got=%b exp=0", sout); end
    endtask

    task automatic test_abort();
        int ndone;
        ndone = 0;
        load = 1; din = 8'h01; step(); load = 0;
        start = 1; count = 8; mode = 2'b10; step(); start = 0;
        step(); step();
        checks++; if (out !== 8'h04) begin failures++; $display("FAIL abort_pre got=%h exp=04", out); end
        load = 1; din = 8'h3C; step(); load = 0;
        checks++; if (out !== 8'h3C || busy !== 1'b0) begin
            failures++; $display("FAIL abort_load got out=%h busy=%b exp out=3c busy=0", out, busy);
        end
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) ndone++;
            step();
        end
        checks++; if (ndone != 0 || out !== 8'h3C) begin
            failures++; $display("FAIL abort_after got done_cnt=%0d out=%h exp 0/3c", ndone, out);
        end
    endtask

    task automatic test_zero_count();
        int ndone;
        load = 1; din = 8'h55; step(); load = 0;
        start = 1; count = 0; step(); start = 0;
        checks++; if (done !== 1'b1 || busy !== 1'b0 || out !== 8'h55) begin
            failures++; $display("FAIL zero_cnt got done=%b busy=%b out=%h exp 1/0/55", done, busy, out);
        end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL zero_cnt_len got=%b exp=0", done); end
        // A start arriving mid-burst is ignored: one done, at the original end.
        start = 1; count = 2; mode = 2'b10; step();
        count = 0; step(); start = 0;
        checks++; if (done !== 1'b0 || busy !== 1'b1 || out !== 8'hAA) begin
            failures++; $display("FAIL ignore_start got done=%b busy=%b out=%h exp 0/1/aa", done, busy, out);
        end
        ndone = 0;
        for (int i = 0; i < 4; i++) begin step(); if (done === 1'b1) ndone++; end
        checks++; if (ndone != 1 || out !== 8'h55) begin
            failures++; $display("FAIL ignore_start_end got done_cnt=%0d out=%h exp 1/55", ndone, out);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        load = 1; din = 8'hF0; step(); load = 0;
        start = 1; count = 5; mode = 2'b00; sin = 0; step(); start = 0;
        step(); step();
        #2 rst = 1'b0;
        #1;
        checks++; if (out !== 8'h00 || busy !== 1'b0 || done !== 1'b0 || sout !== 1'b0) begin
            failures++;
            $display("FAIL async_rst got out=%h busy=%b done=%b sout=%b exp all 0", out, busy, done, sout);
        end
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin step(); if (done !== 1'b0 || busy !== 1'b0) bad++; end
        checks++; if (bad != 0 || out !== 8'h00) begin
            failures++; $display("FAIL async_rst_after got bad=%0d out=%h exp 0/00", bad, out);
        end
    endtask

    task automatic test_random();
        do_reset();
        m_out = '0; m_sout = 0; m_busy = 0; m_done = 0; m_rem = 0; m_mode = 2'b00;
        for (int i = 0; i < 600; i++) begin
            load  = ($urandom_range(0, 19) == 0);
            start = ($urandom_range(0, 4) == 0);
            en    = $urandom_range(0, 1) == 1;
            mode  = 2'($urandom_range(0, 3));
            sin   = $urandom_range(0, 1) == 1;
            count = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            din   = 8'($urandom);
            model_edge();
            step();
            checks++;
            if (out !== m_out || sout !== m_sout || busy !== m_busy || done !== m_done) begin
                failures++;
                $display("FAIL random cyc=%0d got out=%h sout=%b busy=%b done=%b exp out=%h sout=%b busy=%b done=%b",
                         i, out, sout, busy, done, m_out, m_sout, m_busy, m_done);
            end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_shift();
        test_burst_rotr();
        test_burst_shr();
        test_abort();
        test_zero_count();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
